// File: rtl/key_debouncer.sv
// key_debouncer: 2-flop sync + per-key debounce FSM with press/release strobes and hit index; KEY_REPEAT_EN adds auto-repeat
module key_debouncer #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int IDX_W           = 2,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              any_press,
  output logic [IDX_W-1:0]  press_idx
);
  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] HELD         = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (N_KEYS < 1 || N_KEYS > 16 || DEBOUNCE_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES) ||
      (64'd1 << IDX_W) < 64'(N_KEYS) || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("key_debouncer: illegal parameter set");
  end

  logic [N_KEYS-1:0] sync1_q, sync1_d, sync2_q, sync2_d, s;
  logic [1:0]        state_q [N_KEYS];
  logic [1:0]        state_d [N_KEYS];
  logic [CNT_W-1:0]  cnt_q   [N_KEYS];
  logic [CNT_W-1:0]  cnt_d   [N_KEYS];
  logic [N_KEYS-1:0] level_q, level_d, press_q, press_d, release_q, release_d;
  logic              any_q, any_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DLY = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PER = REP_W'(REPEAT_PERIOD - 1);
  logic [REP_W-1:0]  rep_q [N_KEYS];
  logic [REP_W-1:0]  rep_d [N_KEYS];
  logic [N_KEYS-1:0] first_q, first_d;
`endif

  always_comb begin
    sync1_d   = KEY;
    sync2_d   = sync1_q;
    s         = ~sync2_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
`ifdef KEY_REPEAT_EN
    rep_d     = rep_q;
    first_d   = first_q;
`endif
    for (int i = 0; i < N_KEYS; i++) begin
      case (state_q[i])
        IDLE: if (s[i]) begin
          state_d[i] = PRESS_WAIT;
          cnt_d[i]   = '0;
        end
        PRESS_WAIT: if (!s[i]) state_d[i] = IDLE;
        else if (cnt_q[i] == CNT_MAX) begin
          state_d[i] = HELD;
          level_d[i] = 1'b1;
          press_d[i] = 1'b1;
        end else cnt_d[i] = cnt_q[i] + 1'b1;
        HELD: if (!s[i]) begin
          state_d[i] = RELEASE_WAIT;
          cnt_d[i]   = '0;
        end
        default: if (s[i]) state_d[i] = HELD;
        else if (cnt_q[i] == CNT_MAX) begin
          state_d[i]   = IDLE;
          level_d[i]   = 1'b0;
          release_d[i] = 1'b1;
        end else cnt_d[i] = cnt_q[i] + 1'b1;
      endcase
`ifdef KEY_REPEAT_EN
      // RELEASE_WAIT neither counts nor clears, so a release bounce only pauses repeats
      if (state_q[i] == HELD) begin
        if (rep_q[i] == (first_q[i] ? REP_DLY : REP_PER)) begin
          press_d[i] = 1'b1;
          rep_d[i]   = '0;
          first_d[i] = 1'b0;
        end else rep_d[i] = rep_q[i] + 1'b1;
      end else if (state_q[i] != RELEASE_WAIT) begin
        rep_d[i]   = '0;
        first_d[i] = 1'b1;
      end
`endif
    end
    any_d = |press_d;
    idx_d = idx_q;
    for (int i = N_KEYS - 1; i >= 0; i--)
      if (press_d[i]) idx_d = IDX_W'(i);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      state_q   <= '{default: IDLE};
      cnt_q     <= '{default: '0};
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
      idx_q     <= '0;
`ifdef KEY_REPEAT_EN
      rep_q     <= '{default: '0};
      first_q   <= '1;
`endif
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= any_d;
      idx_q     <= idx_d;
`ifdef KEY_REPEAT_EN
      rep_q     <= rep_d;
      first_q   <= first_d;
`endif
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign any_press   = any_q;
  assign press_idx   = idx_q;
endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed checks of sync latency, debounce, strobes, hit index, async reset and auto-repeat
module tb_key_debouncer;
  localparam int D = 8;
`ifdef KEY_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  logic       CLOCK_50 = 1'b0;
  logic       RESET_N = 1'b0;
  logic [3:0] KEY = '1;
  logic [3:0] key_level, key_press, key_release;
  logic       any_press;
  logic [1:0] press_idx;
  int         checks = 0, failures = 0;
  logic       bad_press, bad_level;

  always #5 CLOCK_50 = ~CLOCK_50;

  key_debouncer #(
    .N_KEYS(4), .DEBOUNCE_CYCLES(D), .CNT_W(4), .IDX_W(2),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(10)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .KEY(KEY),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .any_press(any_press), .press_idx(press_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    #12;
    check("rst_level", 32'(key_level), 0);
    check("rst_press", 32'(key_press), 0);
    check("rst_release", 32'(key_release), 0);
    check("rst_any", 32'(any_press), 0);
    check("rst_idx", 32'(press_idx), 0);
    tick(2);
    RESET_N = 1'b1;
    tick(3);
    check("idle_level", 32'(key_level), 0);
    // clean press: first sampling edge + D+2 more edges
    KEY[0] = 1'b0;
    tick(D + 2);
    check("press_early", 32'(key_press), 0);
    tick();
    check("press0", 32'(key_press), 32'h1);
    check("press0_any", 32'(any_press), 1);
    check("press0_idx", 32'(press_idx), 0);
    check("press0_level", 32'(key_level), 32'h1);
    tick();
    check("press0_one_cycle", 32'(key_press[0]), 0);
    check("press0_any_off", 32'(any_press), 0);
    check("level0_held", 32'(key_level), 32'h1);
    bad_press = 1'b0;
    bad_level = 1'b0;
    for (int i = 0; i < 52; i++) begin
      KEY[1] = i >= 40 ? 1'b1 : (((i / 3) % 2) == 0 ? 1'b0 : 1'b1);
      tick();
      bad_press |= key_press[1];
      bad_level |= key_level[1];
    end
    check("bounce_press", 32'(bad_press), 0);
    check("bounce_level", 32'(bad_level), 0);
    KEY[0] = 1'b1;
    tick(D + 2);
    check("release_early", 32'(key_release), 0);
    check("level_before_rel", 32'(key_level[0]), 1);
    tick();
    check("release0", 32'(key_release), 32'h1);
    check("release0_level", 32'(key_level), 0);
    check("release0_no_press", 32'(key_press[0]), 0);
    tick();
    check("release0_one_cycle", 32'(key_release), 0);
    KEY[3] = 1'b0;
    KEY[1] = 1'b0;
    tick(D + 3);
    check("simul_press", 32'(key_press), 32'hA);
    check("simul_any", 32'(any_press), 1);
    check("simul_idx", 32'(press_idx), 1);
    tick();
    check("simul_press_off", 32'(key_press), 0);
    check("simul_idx_held", 32'(press_idx), 1);
    check("simul_level", 32'(key_level), 32'hA);
    KEY = '1;
    tick(D + 3);
    check("simul_release", 32'(key_release), 32'hA);
    check("simul_rel_level", 32'(key_level), 0);
    tick(3);
    KEY[3] = 1'b0;
    tick(D + 4);
    check("k3_level", 32'(key_level), 32'h8);
    check("k3_idx", 32'(press_idx), 3);
    KEY[2] = 1'b0;
    tick(8);
    #2 RESET_N = 1'b0;
    #1;
    check("async_level", 32'(key_level), 0);
    check("async_idx", 32'(press_idx), 0);
    check("async_press", 32'(key_press), 0);
    check("async_any", 32'(any_press), 0);
    KEY[3] = 1'b1;
    tick();
    RESET_N = 1'b1;
    tick(D + 2);
    check("post_rst_early", 32'(key_press), 0);
    tick();
    check("post_rst_press", 32'(key_press), 32'h4);
    check("post_rst_idx", 32'(press_idx), 2);
    check("post_rst_any", 32'(any_press), 1);
    KEY[2] = 1'b1;
    tick(D + 6);
    check("post_rst_idle", 32'(key_level), 0);
    // auto-repeat window; default build expects the single initial press only
    KEY[0] = 1'b0;
    tick(D + 3);
    check("rep_first", 32'(key_press), 32'h1);
    for (int k = 1; k <= 70; k++) begin
      tick();
      check($sformatf("rep_press_%0d", k), 32'(key_press[0]),
            32'(REP && k >= 20 && k <= 50 && (k % 10) == 0));
      check($sformatf("rep_release_%0d", k), 32'(key_release[0]), 32'(k == 66));
      if (k == 55) KEY[0] = 1'b1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
